// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer: buffers X/Y samples and frames them (A5,X,Y[,CHK]) onto the TX core DE/busy handshake.
// Define UART_PKT_CHECKSUM_EN to append the checksum byte (6-byte frames instead of 5).
module uart_tx_packetizer #(
  parameter int         FIFO_AW = 2,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iSAMPLE_VALID,
  input  logic [15:0] iX,
  input  logic [15:0] iY,
  input  logic        iDROP_CLR,
  output logic        oTX_DE,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_BUSY,
  output logic        oPKT_BUSY,
  output logic [7:0]  oDROP_CNT
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = FIFO_AW + 1;
`ifdef UART_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd4;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, ASSERT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0] frame, frame_n;
  logic [2:0] idx, idx_n;
  logic de_n, full, push, drop, pop;
  logic [7:0] data_n, next_byte, chk;
  assign full = count == CW'(DEPTH);
  assign push = iSAMPLE_VALID && !full;
  assign drop = iSAMPLE_VALID && full;
  assign pop = state == LOAD;
`ifdef UART_PKT_CHECKSUM_EN
  assign chk = frame[31:24] + frame[23:16] + frame[15:8] + frame[7:0];
`else
  assign chk = 8'h00;
`endif
  // byte following the current index; frame holds {X, Y}
  assign next_byte = idx == 3'd0 ? frame[31:24] :
                     idx == 3'd1 ? frame[23:16] :
                     idx == 3'd2 ? frame[15:8]  :
                     idx == 3'd3 ? frame[7:0]   : chk;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame     <= '0;
      idx       <= '0;
      oTX_DE    <= 1'b0;
      oTX_DATA  <= 8'h00;
      oPKT_BUSY <= 1'b0;
      oDROP_CNT <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_n;
      frame     <= frame_n;
      idx       <= idx_n;
      oTX_DE    <= de_n;
      oTX_DATA  <= data_n;
      oPKT_BUSY <= state != IDLE || count != '0;
      if (push) begin
        mem[wr_ptr] <= {iX, iY};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
      oDROP_CNT <= iDROP_CLR ? {7'd0, drop} : (drop && oDROP_CNT != 8'hFF) ? oDROP_CNT + 8'd1 : oDROP_CNT;
    end
  // DE drops on the first busy cycle; data stays put until busy releases
  always_comb begin
    state_n = state;
    de_n    = oTX_DE;
    data_n  = oTX_DATA;
    idx_n   = idx;
    frame_n = frame;
    case (state)
      IDLE: state_n = count != '0 ? LOAD : IDLE;
      LOAD: begin
        frame_n = mem[rd_ptr];
        idx_n   = 3'd0;
        de_n    = 1'b1;
        data_n  = HEADER;
        state_n = ASSERT;
      end
      ASSERT: if (iTX_BUSY) begin
        de_n    = 1'b0;
        state_n = HOLD;
      end
      HOLD: if (!iTX_BUSY) begin
        if (idx != LAST) begin
          idx_n   = idx + 3'd1;
          data_n  = next_byte;
          de_n    = 1'b1;
          state_n = ASSERT;
        end else state_n = count != '0 ? LOAD : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer: directed bench with a TX core model (busy 2 cycles after DE, held 40 cycles).
`timescale 1ns/1ps
module tb_uart_tx_packetizer;
  logic CLK = 1'b0, RST = 1'b1, iSAMPLE_VALID = 1'b0, iDROP_CLR = 1'b0, iTX_BUSY = 1'b0;
  logic [15:0] iX = '0, iY = '0;
  logic oTX_DE, oPKT_BUSY;
  logic [7:0] oTX_DATA, oDROP_CNT;
  int n_chk = 0, n_fail = 0, cyc = 0, rel_cyc = 0, done = 0;
  bit tx_en = 0, stable;
  logic [7:0] held;
  logic [7:0] rx_q[$], exp_q[$];
`ifdef UART_PKT_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  uart_tx_packetizer #(.FIFO_AW(2), .HEADER(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .iSAMPLE_VALID(iSAMPLE_VALID), .iX(iX), .iY(iY),
    .iDROP_CLR(iDROP_CLR), .oTX_DE(oTX_DE), .oTX_DATA(oTX_DATA), .iTX_BUSY(iTX_BUSY),
    .oPKT_BUSY(oPKT_BUSY), .oDROP_CNT(oDROP_CNT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // TX core model: capture byte, raise busy, hold it, release
  initial forever begin
    @(negedge CLK);
    if (tx_en && oTX_DE && !RST) begin
      held = oTX_DATA;
      rx_q.push_back(held);
      @(negedge CLK);
      iTX_BUSY = 1'b1;
      @(negedge CLK);
      if (!RST) check("de_drop", oTX_DE, 0);
      stable = 1;
      for (int i = 0; i < 40 && !RST; i++) begin
        if (oTX_DATA !== held) stable = 0;
        @(negedge CLK);
      end
      if (!RST) check("data_hold", stable, 1);
      iTX_BUSY = 1'b0;
      rel_cyc = cyc;
      done++;
    end
  end
  task automatic write(input logic [15:0] x, input logic [15:0] y);
    iSAMPLE_VALID = 1'b1;
    iX = x;
    iY = y;
    @(negedge CLK);
    iSAMPLE_VALID = 1'b0;
  endtask
  function automatic void add_frame(input logic [15:0] x, input logic [15:0] y);
    exp_q.push_back(8'hA5);
    exp_q.push_back(x[15:8]);
    exp_q.push_back(x[7:0]);
    exp_q.push_back(y[15:8]);
    exp_q.push_back(y[7:0]);
    if (FLEN == 6) exp_q.push_back(x[15:8] + x[7:0] + y[15:8] + y[7:0]);
  endfunction
  task automatic wait_and_compare(input string tag);
    for (int i = 0; i < 20000 && done < exp_q.size(); i++) @(negedge CLK);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
    for (int i = 0; i < 20 && oPKT_BUSY; i++) @(negedge CLK);
    check({tag, "_idle_lat"}, cyc - rel_cyc, 2);
    rx_q.delete();
    exp_q.delete();
    done = 0;
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_de", oTX_DE, 0);
    check("rst_data", oTX_DATA, 8'h00);
    check("rst_pkt", oPKT_BUSY, 0);
    check("rst_drop", oDROP_CNT, 0);
    RST = 1'b0;
    tx_en = 1;
    @(negedge CLK);
    write(16'h1234, 16'h5678);
    check("lat_k0_de", oTX_DE, 0);
    @(negedge CLK);
    check("lat_k1_de", oTX_DE, 0);
    @(negedge CLK);
    check("lat_k2_de", oTX_DE, 1);
    check("lat_hdr", oTX_DATA, 8'hA5);
    exp_q = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78};
    if (FLEN == 6) exp_q.push_back(8'h14);
    wait_and_compare("single");
    write(16'hFFFF, 16'hFF02);
    repeat (3) @(negedge CLK);
    write(16'h0102, 16'h0304);
    write(16'h1111, 16'h2222);
    write(16'h8000, 16'h7FFF);
    write(16'hDEAD, 16'hBEEF);
    write(16'h5555, 16'hAAAA);
    check("drop_one", oDROP_CNT, 1);
    exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h02};
    if (FLEN == 6) exp_q.push_back(8'hFF);
    add_frame(16'h0102, 16'h0304);
    add_frame(16'h1111, 16'h2222);
    add_frame(16'h8000, 16'h7FFF);
    add_frame(16'hDEAD, 16'hBEEF);
    wait_and_compare("burst");
    tx_en = 0;
    write(16'h0000, 16'h0000);
    repeat (3) @(negedge CLK);
    iSAMPLE_VALID = 1'b1;
    repeat (304) @(negedge CLK);
    iSAMPLE_VALID = 1'b0;
    check("drop_sat", oDROP_CNT, 255);
    check("parked_de", oTX_DE, 1);
    check("parked_pkt", oPKT_BUSY, 1);
    iSAMPLE_VALID = 1'b1;
    iDROP_CLR = 1'b1;
    @(negedge CLK);
    iSAMPLE_VALID = 1'b0;
    iDROP_CLR = 1'b0;
    check("drop_clr_coinc", oDROP_CNT, 1);
    iDROP_CLR = 1'b1;
    @(negedge CLK);
    iDROP_CLR = 1'b0;
    check("drop_clr", oDROP_CNT, 0);
    #2 RST = 1'b1;
    #1;
    check("rst_parked_de", oTX_DE, 0);
    check("rst_parked_pkt", oPKT_BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    tx_en = 1;
    @(negedge CLK);
    write(16'hABCD, 16'h0011);
    for (int i = 0; i < 2000 && !(rx_q.size() == 3 && iTX_BUSY); i++) @(negedge CLK);
    check("reach_hold3", rx_q.size(), 3);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_hold_de", oTX_DE, 0);
    check("rst_hold_pkt", oPKT_BUSY, 0);
    check("rst_hold_data", oTX_DATA, 8'h00);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("post_rst_idle", oPKT_BUSY, 0);
    rx_q.delete();
    done = 0;
    write(16'hABCD, 16'h0011);
    exp_q = '{8'hA5, 8'hAB, 8'hCD, 8'h00, 8'h11};
    if (FLEN == 6) exp_q.push_back(8'h89);
    wait_and_compare("after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
